// File: rtl/signal_controller_timed.sv
// signal_controller_timed
//   Highway / country-road intersection controller with programmable phase
//   timers, a highway minimum green, a country maximum green, an all-red
//   clearance on both transitions, and a latched pedestrian request that is
//   served with a walk lamp during the following country green.
//
// Ports:
//   clk      in   system clock, rising edge
//   clear    in   asynchronous active-high reset
//   x        in   country-road vehicle sensor (level, sampled each cycle)
//   ped_req  in   pedestrian request (any pulse length is latched)
//   hwy      out  highway lamp  (0 RED, 1 YELLOW, 2 GREEN)
//   cntry    out  country lamp  (same encoding)
//   walk     out  pedestrian walk lamp
//   phase    out  current state code (HG=0 HY=1 AR1=2 CG=3 CY=4 AR2=5)
//
// All outputs come straight from flops; no input has a combinational path
// to an output.
module signal_controller_timed #(
  parameter int TW          = 8,
  parameter int T_HWY_MIN   = 8,
  parameter int T_YEL       = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_CNTRY_MIN = 4,
  parameter int T_CNTRY_MAX = 10
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       x,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } state_e;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  // Last timer value of each timed phase (timer starts at 0 on entry).
  localparam logic [TW-1:0] HWY_LAST    = TW'(T_HWY_MIN - 1);
  localparam logic [TW-1:0] YEL_LAST    = TW'(T_YEL - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] CMIN_LAST   = TW'(T_CNTRY_MIN - 1);
  localparam logic [TW-1:0] CMAX_LAST   = TW'(T_CNTRY_MAX - 1);
  localparam logic [TW-1:0] TIMER_MAX   = '1;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ped_pending_q, ped_pending_d;
  logic            ped_served_q, ped_served_d;
  logic [1:0]      hwy_q, hwy_d;
  logic [1:0]      cntry_q, cntry_d;
  logic            walk_q, walk_d;
  logic            ar1_to_cg;
  logic            cg_to_cy;

  // Next-state and transition detection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HG:  if ((timer_q >= HWY_LAST) && (x || ped_pending_q)) state_d = HY;
      HY:  if (timer_q == YEL_LAST)    state_d = AR1;
      AR1: if (timer_q == ALLRED_LAST) state_d = CG;
      CG:  if ((timer_q == CMAX_LAST) || ((timer_q >= CMIN_LAST) && !x)) state_d = CY;
      CY:  if (timer_q == YEL_LAST)    state_d = AR2;
      AR2: if (timer_q == ALLRED_LAST) state_d = HG;
      default: state_d = HG;           // unreachable codes recover to HG
    endcase
  end

  assign ar1_to_cg = (state_q == AR1) && (state_d == CG);
  assign cg_to_cy  = (state_q == CG)  && (state_d == CY);

  // Timer reloads on any state change and saturates instead of wrapping,
  // which matters only in HG where the phase can be held indefinitely.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // A request on the AR1->CG edge itself re-arms pending, so it is served
  // by the following cycle rather than being lost.
  always_comb begin
    ped_pending_d = ped_req | (ped_pending_q & ~ar1_to_cg);
    ped_served_d  = ped_served_q;
    if (ar1_to_cg) begin
      ped_served_d = ped_pending_q;
    end else if (cg_to_cy) begin
      ped_served_d = 1'b0;
    end
  end

  // Lamp values are decoded from the next state so they land in flops
  // alongside the state itself.
  always_comb begin
    hwy_d   = LAMP_RED;
    cntry_d = LAMP_RED;
    case (state_d)
      HG:      hwy_d   = LAMP_GREEN;
      HY:      hwy_d   = LAMP_YELLOW;
      CG:      cntry_d = LAMP_GREEN;
      CY:      cntry_d = LAMP_YELLOW;
      default: begin
        hwy_d   = LAMP_RED;
        cntry_d = LAMP_RED;
      end
    endcase
    walk_d = (state_d == CG) && ped_served_d;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= HG;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
      ped_served_q  <= 1'b0;
      hwy_q         <= LAMP_GREEN;
      cntry_q       <= LAMP_RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      ped_served_q  <= ped_served_d;
      hwy_q         <= hwy_d;
      cntry_q       <= cntry_d;
      walk_q        <= walk_d;
    end
  end

  assign hwy   = hwy_q;
  assign cntry = cntry_q;
  assign walk  = walk_q;
  assign phase = state_q;

endmodule

// File: tb/tb_signal_controller_timed.sv
// Directed testbench for signal_controller_timed (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_signal_controller_timed;

  logic       clk;
  logic       clear;
  logic       x;
  logic       ped_req;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic [2:0] phase;

  int tests_run;
  int tests_failed;

  signal_controller_timed dut (
    .clk     (clk),
    .clear   (clear),
    .x       (x),
    .ped_req (ped_req),
    .hwy     (hwy),
    .cntry   (cntry),
    .walk    (walk),
    .phase   (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hwy, cntry} for a phase code.
  function automatic logic [3:0] exp_lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    return {2'd2, 2'd0};
      3'd1:    return {2'd1, 2'd0};
      3'd3:    return {2'd0, 2'd2};
      3'd4:    return {2'd0, 2'd1};
      default: return {2'd0, 2'd0};
    endcase
  endfunction

  // Count consecutive falling-edge samples in phase ph (bounded), along with
  // walk-high samples and lamp mismatches. Returns on the first sample of the
  // following phase.
  task automatic measure(input logic [2:0] ph, input int bound,
                         output int len, output int walks, output int lamp_bad);
    len = 0; walks = 0; lamp_bad = 0;
    while (phase === ph && len < bound) begin
      len++;
      if (walk === 1'b1) walks++;
      if ({hwy, cntry} !== exp_lamps(ph)) lamp_bad++;
      @(negedge clk);
    end
  endtask

  // Hold clear for a few edges, release on a falling edge: HG, timer=0.
  task automatic do_reset();
    clear = 1'b1; x = 1'b0; ped_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; x = 1'b0; ped_req = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({hwy, cntry, walk, phase} !== {2'd2, 2'd0, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: got hwy=%0d cntry=%0d walk=%0d phase=%0d required 2 0 0 0",
               hwy, cntry, walk, phase);
    end
    clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tests_run++;
      if ({hwy, cntry, walk, phase} !== {2'd2, 2'd0, 1'b0, 3'd0}) begin
        tests_failed++;
        $display("FAIL idle_hold cycle %0d: got hwy=%0d cntry=%0d walk=%0d phase=%0d required 2 0 0 0",
                 i, hwy, cntry, walk, phase);
      end
      @(negedge clk);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_vehicle_cycle();
    int exp_ph [7] = '{1, 2, 3, 4, 5, 0, 1};
    int exp_len[7] = '{3, 1, 10, 3, 1, 8, 3};
    int len, walks, bad, walk_tot, bad_tot;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    x = 1'b1;                      // HG timer=2 here
    measure(3'd0, 50, len, walks, bad);
    tests_run++;
    if (len + 2 != 8) begin
      tests_failed++;
      $display("FAIL veh_hg_len: got %0d required 8", len + 2);
    end
    walk_tot = walks; bad_tot = bad;
    for (int i = 0; i < 7; i++) begin
      measure(3'(exp_ph[i]), 50, len, walks, bad);
      walk_tot += walks; bad_tot += bad;
      tests_run++;
      if (len != exp_len[i]) begin
        tests_failed++;
        $display("FAIL veh_len phase %0d: got %0d required %0d", exp_ph[i], len, exp_len[i]);
      end
    end
    tests_run++;
    if (walk_tot != 0 || bad_tot != 0) begin
      tests_failed++;
      $display("FAIL veh_lamps: walk samples %0d lamp errors %0d required 0 0", walk_tot, bad_tot);
    end
    x = 1'b0;
    $display("[TB] test_vehicle_cycle done");
  endtask

  task automatic test_ped();
    int exp_ph [5] = '{1, 2, 3, 4, 5};
    int exp_len[5] = '{3, 1, 4, 3, 1};
    int exp_wk [5] = '{0, 0, 4, 0, 0};
    int len, walks, bad;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    ped_req = 1'b1;                // HG timer=2
    @(negedge clk);
    ped_req = 1'b0;
    measure(3'd0, 50, len, walks, bad);
    tests_run++;
    if (len + 3 != 8 || walks != 0 || bad != 0) begin
      tests_failed++;
      $display("FAIL ped_hg: got len %0d walk %0d lamp_err %0d required 8 0 0", len + 3, walks, bad);
    end
    for (int i = 0; i < 5; i++) begin
      measure(3'(exp_ph[i]), 50, len, walks, bad);
      tests_run++;
      if (len != exp_len[i] || walks != exp_wk[i] || bad != 0) begin
        tests_failed++;
        $display("FAIL ped_seq phase %0d: got len %0d walk %0d lamp_err %0d required %0d %0d 0",
                 exp_ph[i], len, walks, bad, exp_len[i], exp_wk[i]);
      end
    end
    // Request consumed: HG must now hold.
    measure(3'd0, 30, len, walks, bad);
    tests_run++;
    if (len != 30 || walks != 0) begin
      tests_failed++;
      $display("FAIL ped_no_repeat: got HG len %0d walk %0d required 30 0", len, walks);
    end
    $display("[TB] test_ped done");
  endtask

  task automatic test_cntry_min();
    int len, walks, bad;
    do_reset();
    x = 1'b1;
    measure(3'd0, 50, len, walks, bad);
    measure(3'd1, 50, len, walks, bad);
    measure(3'd2, 50, len, walks, bad);
    tests_run++;
    if (phase !== 3'd3) begin
      tests_failed++;
      $display("FAIL cmin_enter_cg: got phase %0d required 3", phase);
    end
    @(negedge clk);
    x = 1'b0;                      // 2nd CG cycle
    measure(3'd3, 50, len, walks, bad);
    tests_run++;
    if (len + 1 != 4 || bad != 0) begin
      tests_failed++;
      $display("FAIL cmin_cg_len: got %0d lamp_err %0d required 4 0", len + 1, bad);
    end
    measure(3'd4, 50, len, walks, bad);
    tests_run++;
    if (len != 3) begin
      tests_failed++;
      $display("FAIL cmin_cy_len: got %0d required 3", len);
    end
    $display("[TB] test_cntry_min done");
  endtask

  task automatic test_clear_mid();
    int len, walks, bad;
    do_reset();
    x = 1'b1;
    measure(3'd0, 50, len, walks, bad);
    measure(3'd1, 50, len, walks, bad);
    measure(3'd2, 50, len, walks, bad);
    measure(3'd3, 50, len, walks, bad);
    @(negedge clk);                // CY timer=1
    tests_run++;
    if (phase !== 3'd4) begin
      tests_failed++;
      $display("FAIL clr_pre_cy: got phase %0d required 4", phase);
    end
    #2 clear = 1'b1;
    #1;
    tests_run++;
    if ({hwy, cntry, walk, phase} !== {2'd2, 2'd0, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL clr_async: got hwy=%0d cntry=%0d walk=%0d phase=%0d required 2 0 0 0",
               hwy, cntry, walk, phase);
    end
    @(negedge clk);
    clear = 1'b0;
    measure(3'd0, 50, len, walks, bad);
    tests_run++;
    if (len != 8 || bad != 0) begin
      tests_failed++;
      $display("FAIL clr_hg_len: got %0d lamp_err %0d required 8 0", len, bad);
    end
    tests_run++;
    if (phase !== 3'd1) begin
      tests_failed++;
      $display("FAIL clr_then_hy: got phase %0d required 1", phase);
    end
    x = 1'b0;
    $display("[TB] test_clear_mid done");
  endtask

  task automatic test_ped_during_cg();
    int exp_ph [7] = '{4, 5, 0, 1, 2, 3, 4};
    int exp_len[7] = '{3, 1, 8, 3, 1, 4, 3};
    int exp_wk [7] = '{0, 0, 0, 0, 0, 4, 0};
    int len, walks, bad;
    do_reset();
    x = 1'b1;
    measure(3'd0, 50, len, walks, bad);
    measure(3'd1, 50, len, walks, bad);
    measure(3'd2, 50, len, walks, bad);
    tests_run++;
    if (phase !== 3'd3 || walk !== 1'b0) begin
      tests_failed++;
      $display("FAIL pcg_first_cg: got phase %0d walk %0d required 3 0", phase, walk);
    end
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    measure(3'd3, 50, len, walks, bad);
    tests_run++;
    if (len + 1 != 10 || walks != 0) begin
      tests_failed++;
      $display("FAIL pcg_no_midwalk: got CG len %0d walk %0d required 10 0", len + 1, walks);
    end
    x = 1'b0;
    for (int i = 0; i < 7; i++) begin
      measure(3'(exp_ph[i]), 50, len, walks, bad);
      tests_run++;
      if (len != exp_len[i] || walks != exp_wk[i] || bad != 0) begin
        tests_failed++;
        $display("FAIL pcg_seq step %0d phase %0d: got len %0d walk %0d lamp_err %0d required %0d %0d 0",
                 i, exp_ph[i], len, walks, bad, exp_len[i], exp_wk[i]);
      end
    end
    $display("[TB] test_ped_during_cg done");
  endtask

  // Request held across the AR1->CG edge: served now and again next cycle.
  task automatic test_back_to_back();
    int exp_ph [10] = '{3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    int exp_len[10] = '{4, 3, 1, 8, 3, 1, 4, 3, 1, 30};
    int exp_wk [10] = '{4, 0, 0, 0, 0, 0, 4, 0, 0, 0};
    int len, walks, bad;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    measure(3'd0, 50, len, walks, bad);
    measure(3'd1, 50, len, walks, bad);
    ped_req = 1'b1;                // high across the AR1->CG edge
    measure(3'd2, 50, len, walks, bad);
    ped_req = 1'b0;
    tests_run++;
    if (len != 1) begin
      tests_failed++;
      $display("FAIL b2b_ar1_len: got %0d required 1", len);
    end
    for (int i = 0; i < 10; i++) begin
      measure(3'(exp_ph[i]), exp_len[i] == 30 ? 30 : 50, len, walks, bad);
      tests_run++;
      if (len != exp_len[i] || walks != exp_wk[i] || bad != 0) begin
        tests_failed++;
        $display("FAIL b2b_seq step %0d phase %0d: got len %0d walk %0d lamp_err %0d required %0d %0d 0",
                 i, exp_ph[i], len, walks, bad, exp_len[i], exp_wk[i]);
      end
    end
    $display("[TB] test_back_to_back done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clear = 1'b1;
    x = 1'b0;
    ped_req = 1'b0;
    test_reset();
    test_vehicle_cycle();
    test_ped();
    test_cntry_min();
    test_clear_mid();
    test_ped_during_cg();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/signal_controller_timed.md
Name: signal_controller_timed

Overview:
Parametrised successor to the highway/country-road signal controller. Adds programmable phase timers, a highway minimum-green time, a country maximum-green time and an all-red clearance interval. Adds a latched pedestrian request that is served with a walk indication during country green. It sits between the vehicle/pedestrian sensors and the lamp drivers of one intersection.

Parameters:
TW, 8, timer width in bits. Every timing parameter must be in the range 1 .. 2^TW-1.
T_HWY_MIN, 8, minimum highway-green duration in cycles.
T_YEL, 3, yellow duration in cycles (both roads).
T_ALLRED, 1, all-red clearance duration in cycles (both transitions).
T_CNTRY_MIN, 4, minimum country-green duration in cycles.
T_CNTRY_MAX, 10, maximum country-green duration in cycles. Must be >= T_CNTRY_MIN.

Ports:
clk  input  1  system clock; all state changes on its rising edge
clear  input  1  asynchronous, active-high reset
x  input  1  country-road vehicle sensor, level-sampled each cycle
ped_req  input  1  pedestrian request; a pulse of any length is latched
hwy  output  2  highway lamp: 2'd0 RED, 2'd1 YELLOW, 2'd2 GREEN
cntry  output  2  country lamp, same encoding as hwy
walk  output  1  pedestrian walk lamp
phase  output  3  current state code, for debug and verification

Behaviour:
- The design has one clock and an asynchronous, active-high reset. Clock port is clk; reset port is clear.
- Moore machine. hwy, cntry, walk and phase decode only from registered state and flags; inputs never reach outputs combinationally.
- States and phase codes: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5. Codes 6 and 7 are unreachable; if entered, go to HG on the next edge.
- Lamps per state:
  - HG: hwy=GREEN, cntry=RED.
  - HY: hwy=YELLOW, cntry=RED.
  - AR1 and AR2: both RED.
  - CG: hwy=RED, cntry=GREEN.
  - CY: hwy=RED, cntry=YELLOW.
- Timer: a TW-bit counter. It is 0 on the first cycle in any state and increments by 1 each cycle. In HG it saturates at all-ones and never wraps. It reloads to 0 on every state change.
- HG to HY: on the edge where timer >= T_HWY_MIN-1 and (x==1 or ped_pending==1). Otherwise HG is held indefinitely.
- HY to AR1: when timer == T_YEL-1. HY lasts exactly T_YEL cycles.
- AR1 to CG: when timer == T_ALLRED-1.
- CG to CY: when timer == T_CNTRY_MAX-1, or when (timer >= T_CNTRY_MIN-1 and x==0).
- CY to AR2: when timer == T_YEL-1.
- AR2 to HG: when timer == T_ALLRED-1.
- x is not latched. A pulse of x that falls before the HG minimum expires has no effect.
- ped_pending:
  - Set on any cycle with ped_req==1.
  - Cleared on the AR1 to CG edge. On that same edge ped_served is set to the old ped_pending.
  - If ped_req is high on the AR1 to CG edge, the set wins: ped_pending stays 1 for the next cycle.
- ped_served is cleared on the CG to CY edge. walk = (state==CG) && ped_served.
- A request arriving during CG does not start walk mid-phase. It stays pending and is served in the next cycle.
- Reset (clear=1), applied immediately without waiting for clk:
  - state=HG, timer=0, ped_pending=0, ped_served=0.
  - Outputs: hwy=GREEN, cntry=RED, walk=0, phase=0.
  - Clear is allowed in any state, including mid-yellow; no yellow is inserted.
  - After release, HG starts with timer=0.

Test Plan:
- clear=1 for 5 edges, then x=0, ped_req=0 for 40 cycles -> hwy=2, cntry=0, walk=0, phase=0 on every cycle.
- x=1 held from 2 cycles after clear release -> HG lasts 8 cycles, HY 3, AR1 1, CG 10 (max-out), CY 3, AR2 1. Then HG lasts 8 again and the sequence repeats.
- ped_req pulse for 1 cycle at HG timer=2 with x=0 -> HY entered after HG timer=7. walk=1 for all 4 CG cycles, 0 elsewhere. ped_pending=0 afterwards and no second cycle follows.
- x=1 until the 2nd CG cycle, then x=0 -> CG lasts exactly 4 cycles (T_CNTRY_MIN). Then CY for 3 cycles.
- clear pulsed mid-CY with no clk edge in between -> hwy=2, cntry=0, walk=0, phase=0 immediately. After release, the next transition still needs 8 HG cycles.
- ped_req during CG of a vehicle-only cycle -> walk stays 0 through that CG. Next cycle follows: walk=1 throughout its CG.
